pipeline_hazard_ctrl: RTL and testbench

- Control end of the pipeline-register write/flush interface.
- Generates the per-stage write enables that the IF/ID, ID/EX, EX/MEM and MEM/WB registers sample. Also generates the flush (bubble) strobes for IF/ID and ID/EX.
- Detects three conditions: load-use hazards, multi-cycle data-memory waits, and taken branches.
- Enforces a bounded memory wait with a sticky timeout that halts the core.

---
 rtl/pipeline_hazard_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Control end of the pipeline-register write/flush interface. Produces the
//   PC and per-stage pipeline-register write enables plus the IF/ID and ID/EX
//   flush strobes. Handles load-use hazards, taken branches and multi-cycle
//   data-memory waits, with a bounded wait that halts the core on timeout.
//
//   Optional build macro: HAZARD_STATS_EN (adds stall/flush counters).
//
// Parameters:
//   MAX_WAIT  consecutive memory-wait cycles tolerated (2..255)
//   REG_AW    register address width
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   MemRead_EX, RD_EX          load in EX and its destination register
//   RS_ID, RT_ID, UsesRT_ID    source registers of the ID instruction
//   branch_taken_EX            branch resolved taken in EX
//   mem_req_MEM, mem_ready     data-memory access in MEM / completion
//   pc_write .. mem_wb_write   write enables (PC, IF/ID, ID/EX, EX/MEM, MEM/WB)
//   if_id_flush, id_ex_flush   bubble strobes
//   mem_timeout                sticky memory-timeout error
//   state_o                    FSM state (RUN=0, MEM_WAIT=1, HALT=2)
//   stall_cycles, flush_count  event counters (HAZARD_STATS_EN only)
module pipeline_hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int REG_AW   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead_EX,
    input  logic [REG_AW-1:0] RD_EX,
    input  logic [REG_AW-1:0] RS_ID,
    input  logic [REG_AW-1:0] RT_ID,
    input  logic              UsesRT_ID,
    input  logic              branch_taken_EX,
    input  logic              mem_req_MEM,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_write,
    output logic              ex_mem_write,
    output logic              mem_wb_write,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              mem_timeout,
    output logic [1:0]        state_o
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_count
`endif
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2,
        BAD      = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   wait_cnt;
    logic [CNT_W-1:0]   wait_cnt_next;
    logic               timeout_set;

    logic               mem_stall;
    logic               load_use;

    // Enables ordered {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [4:0]         run_en;
    logic               run_if_flush;
    logic               run_id_flush;
    logic [4:0]         en;
    logic               if_flush;
    logic               id_flush;

    assign mem_stall = mem_req_MEM & ~mem_ready;
    assign load_use  = MemRead_EX & (RD_EX != '0) &
                       ((RD_EX == RS_ID) | (UsesRT_ID & (RD_EX == RT_ID)));

    // Hazard resolution when memory is not holding the pipeline. A taken
    // branch squashes the ID instruction, so any load-use on it is moot.
    always_comb begin
        run_en       = 5'b11111;
        run_if_flush = 1'b0;
        run_id_flush = 1'b0;
        if (branch_taken_EX) begin
            run_if_flush = 1'b1;
            run_id_flush = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID, inject a bubble into ID/EX for one cycle
            run_en       = 5'b00111;
            run_id_flush = 1'b1;
        end
    end

    always_comb begin
        en            = 5'b00000;
        if_flush      = 1'b0;
        id_flush      = 1'b0;
        state_next    = state;
        wait_cnt_next = wait_cnt;
        timeout_set   = 1'b0;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_next    = MEM_WAIT;
                    wait_cnt_next = CNT_W'(1);
                end else begin
                    en       = run_en;
                    if_flush = run_if_flush;
                    id_flush = run_id_flush;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    // Release cycle also services any branch/load-use that
                    // was frozen behind the memory wait.
                    en            = run_en;
                    if_flush      = run_if_flush;
                    id_flush      = run_id_flush;
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt < CNT_W'(MAX_WAIT)) begin
                    wait_cnt_next = wait_cnt + CNT_W'(1);
                end else begin
                    state_next  = HALT;
                    timeout_set = 1'b1;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase
        // Outputs are Mealy, so reset must also gate them directly
        if (reset) begin
            en       = 5'b00000;
            if_flush = 1'b0;
            id_flush = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_next;
            wait_cnt    <= wait_cnt_next;
            mem_timeout <= mem_timeout | timeout_set;
        end
    end

    assign {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write} = en;
    assign if_id_flush = if_flush;
    assign id_ex_flush = id_flush;
    assign state_o     = state;

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_write && state != HALT && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
            if (if_id_flush && flush_count != 32'hFFFF_FFFF)
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

    localparam int MAX_WAIT = 16;
    localparam int REG_AW   = 5;

    localparam logic [4:0] ALL   = 5'b11111;
    localparam logic [4:0] NONE  = 5'b00000;
    localparam logic [4:0] LUSTL = 5'b00111;
    localparam logic [1:0] S_RUN = 2'd0;
    localparam logic [1:0] S_MW  = 2'd1;
    localparam logic [1:0] S_HLT = 2'd2;

    logic              clk = 1'b0;
    logic              reset;
    logic              MemRead_EX;
    logic [REG_AW-1:0] RD_EX;
    logic [REG_AW-1:0] RS_ID;
    logic [REG_AW-1:0] RT_ID;
    logic              UsesRT_ID;
    logic              branch_taken_EX;
    logic              mem_req_MEM;
    logic              mem_ready;
    logic              pc_write;
    logic              if_id_write;
    logic              id_ex_write;
    logic              ex_mem_write;
    logic              mem_wb_write;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic              mem_timeout;
    logic [1:0]        state_o;
`ifdef HAZARD_STATS_EN
    logic [31:0]       stall_cycles;
    logic [31:0]       flush_count;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    string      tag_q[$];
    logic [9:0] exp_q[$];
    logic [9:0] obs;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .REG_AW(REG_AW)) dut (
        .clk(clk),
        .reset(reset),
        .MemRead_EX(MemRead_EX),
        .RD_EX(RD_EX),
        .RS_ID(RS_ID),
        .RT_ID(RT_ID),
        .UsesRT_ID(UsesRT_ID),
        .branch_taken_EX(branch_taken_EX),
        .mem_req_MEM(mem_req_MEM),
        .mem_ready(mem_ready),
        .pc_write(pc_write),
        .if_id_write(if_id_write),
        .id_ex_write(id_ex_write),
        .ex_mem_write(ex_mem_write),
        .mem_wb_write(mem_wb_write),
        .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush),
        .mem_timeout(mem_timeout),
        .state_o(state_o)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_count(flush_count)
`endif
    );

    assign obs = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                  if_id_flush, id_ex_flush, mem_timeout, state_o};

    function automatic logic [9:0] ev(input logic [4:0] e, input logic fi,
                                      input logic fe, input logic to,
                                      input logic [1:0] st);
        return {e, fi, fe, to, st};
    endfunction

    task automatic quiet();
        MemRead_EX      = 1'b0;
        RD_EX           = '0;
        RS_ID           = '0;
        RT_ID           = '0;
        UsesRT_ID       = 1'b0;
        branch_taken_EX = 1'b0;
        mem_req_MEM     = 1'b0;
        mem_ready       = 1'b0;
    endtask

    task automatic rand_inputs();
        logic [31:0] r;
        r = $urandom;
        MemRead_EX      = r[0];
        RD_EX           = r[5:1];
        RS_ID           = r[10:6];
        RT_ID           = r[15:11];
        UsesRT_ID       = r[16];
        branch_taken_EX = r[17];
        mem_req_MEM     = r[18];
        mem_ready       = r[19];
    endtask

    // Push the expectation, compare at the falling edge, return just after
    // the next rising edge so the caller can drive the following step.
    task automatic step(input string tag, input logic [9:0] e);
        string      t;
        logic [9:0] x;
        tag_q.push_back(tag);
        exp_q.push_back(e);
        @(negedge clk);
        t = tag_q.pop_front();
        x = exp_q.pop_front();
        n_cmp++;
        assert (obs === x) else begin
            n_bad++;
            $error("FAIL %s: observed %b required %b", t, obs, x);
        end
        @(posedge clk);
        #1;
    endtask

`ifdef HAZARD_STATS_EN
    task automatic check_cnt(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: observed %0d required %0d", tag, o, e);
        end
    endtask
`endif

    initial begin
        quiet();
        reset = 1'b1;

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            step("reset", ev(NONE, 0, 0, 0, S_RUN));
        end
        reset = 1'b0;
        quiet();
        step("release", ev(ALL, 0, 0, 0, S_RUN));

        // Load-use on RS
        MemRead_EX = 1'b1; RD_EX = 5'd5; RS_ID = 5'd5;
        step("lu_rs", ev(LUSTL, 0, 1, 0, S_RUN));
        quiet();
        step("after_lu", ev(ALL, 0, 0, 0, S_RUN));
        // r0 destination never hazards
        MemRead_EX = 1'b1; RD_EX = 5'd0; RS_ID = 5'd0;
        step("lu_rd0", ev(ALL, 0, 0, 0, S_RUN));
        // RT match ignored unless RT is used
        MemRead_EX = 1'b1; RD_EX = 5'd5; RS_ID = 5'd3; RT_ID = 5'd5; UsesRT_ID = 1'b0;
        step("lu_rt_unused", ev(ALL, 0, 0, 0, S_RUN));
        UsesRT_ID = 1'b1;
        step("lu_rt", ev(LUSTL, 0, 1, 0, S_RUN));
        quiet();
        RD_EX = 5'd5; RS_ID = 5'd5;
        step("no_load", ev(ALL, 0, 0, 0, S_RUN));
        // Branch dominates load-use
        MemRead_EX = 1'b1; branch_taken_EX = 1'b1;
        step("br_over_lu", ev(ALL, 1, 1, 0, S_RUN));

        // 4-cycle memory wait
        quiet();
        mem_req_MEM = 1'b1;
        step("mw4_first", ev(NONE, 0, 0, 0, S_RUN));
        for (int i = 0; i < 3; i++) step("mw4_wait", ev(NONE, 0, 0, 0, S_MW));
        mem_ready = 1'b1;
        step("mw4_rel", ev(ALL, 0, 0, 0, S_MW));
        quiet();
        step("mw4_after", ev(ALL, 0, 0, 0, S_RUN));

        // Load-use frozen during a wait is serviced on the release cycle
        mem_req_MEM = 1'b1;
        step("mwlu_first", ev(NONE, 0, 0, 0, S_RUN));
        MemRead_EX = 1'b1; RD_EX = 5'd7; RS_ID = 5'd7;
        step("mwlu_wait", ev(NONE, 0, 0, 0, S_MW));
        mem_ready = 1'b1;
        step("mwlu_rel", ev(LUSTL, 0, 1, 0, S_MW));
        quiet();
        step("mwlu_after", ev(ALL, 0, 0, 0, S_RUN));

        // Wait of exactly MAX_WAIT stall cycles succeeds
        mem_req_MEM = 1'b1;
        step("mw16_first", ev(NONE, 0, 0, 0, S_RUN));
        for (int i = 1; i < MAX_WAIT; i++) step("mw16_wait", ev(NONE, 0, 0, 0, S_MW));
        mem_ready = 1'b1;
        step("mw16_rel", ev(ALL, 0, 0, 0, S_MW));
        quiet();
        step("mw16_after", ev(ALL, 0, 0, 0, S_RUN));

        // MAX_WAIT+1 stall cycles time out into HALT
        mem_req_MEM = 1'b1;
        step("mw17_first", ev(NONE, 0, 0, 0, S_RUN));
        for (int i = 1; i <= MAX_WAIT; i++) step("mw17_wait", ev(NONE, 0, 0, 0, S_MW));
        quiet();
        mem_ready = 1'b1;
        step("halt", ev(NONE, 0, 0, 1, S_HLT));
        MemRead_EX = 1'b1; RD_EX = 5'd5; RS_ID = 5'd5; branch_taken_EX = 1'b1;
        for (int i = 0; i < 3; i++) step("halt_sticky", ev(NONE, 0, 0, 1, S_HLT));

        // Asynchronous reset out of HALT
        quiet();
        reset = 1'b1;
        step("reset_halt", ev(NONE, 0, 0, 0, S_RUN));
        reset = 1'b0;
        step("rel_halt", ev(ALL, 0, 0, 0, S_RUN));

        // Two load-use stalls, a 3-cycle wait, one branch
        MemRead_EX = 1'b1; RD_EX = 5'd9; RS_ID = 5'd9;
        step("st_lu1", ev(LUSTL, 0, 1, 0, S_RUN));
        quiet();
        step("st_q1", ev(ALL, 0, 0, 0, S_RUN));
        MemRead_EX = 1'b1; RD_EX = 5'd9; RT_ID = 5'd9; UsesRT_ID = 1'b1;
        step("st_lu2", ev(LUSTL, 0, 1, 0, S_RUN));
        quiet();
        mem_req_MEM = 1'b1;
        step("st_mw_first", ev(NONE, 0, 0, 0, S_RUN));
        step("st_mw_wait", ev(NONE, 0, 0, 0, S_MW));
        step("st_mw_wait", ev(NONE, 0, 0, 0, S_MW));
        mem_ready = 1'b1;
        step("st_mw_rel", ev(ALL, 0, 0, 0, S_MW));
        quiet();
        branch_taken_EX = 1'b1;
        step("st_br", ev(ALL, 1, 1, 0, S_RUN));
`ifdef HAZARD_STATS_EN
        check_cnt("stall_cycles", stall_cycles, 32'd5);
        check_cnt("flush_count", flush_count, 32'd1);
`endif
        quiet();
        step("final", ev(ALL, 0, 0, 0, S_RUN));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
